// File: rtl/simon_pkg.sv
// Shared constants and types for the Simon 32/64 datapath.
// SIMON_Z0 uses an ascending range so SIMON_Z0[0] is the leftmost bit of the z0 string.
package simon_pkg;

    localparam int SIMON_WORD_W = 16;
    localparam int SIMON_ROUNDS = 32;

    localparam logic [SIMON_WORD_W-1:0] SIMON_C = 16'hFFFC;

    localparam logic [0:61] SIMON_Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/simon_key_schedule_if.sv
// Key-in / round-key-out handshake bundle of the Simon 32/64 key schedule.
// Both channels are valid/ready: a transfer happens on a posedge where valid and ready are both high.
interface simon_key_schedule_if;
    import simon_pkg::*;

    logic [4*SIMON_WORD_W-1:0] key_in;
    logic                      key_valid;
    logic                      key_ready;
    logic [SIMON_WORD_W-1:0]   rk;
    logic [4:0]                rk_idx;
    logic                      rk_last;
    logic                      rk_valid;
    logic                      rk_ready;

    modport master (
        output key_in, key_valid, rk_ready,
        input  key_ready, rk, rk_idx, rk_last, rk_valid
    );

    modport slave (
        input  key_in, key_valid, rk_ready,
        output key_ready, rk, rk_idx, rk_last, rk_valid
    );

endinterface

// File: rtl/simon_key_expand.sv
// Combinational Simon 32/64 key expansion: next key word from window words w0, w1, w3.
// Kept free of state so an unrolled schedule can instantiate one per round.
module simon_key_expand
    import simon_pkg::*;
(
    input  logic [SIMON_WORD_W-1:0] w0,
    input  logic [SIMON_WORD_W-1:0] w1,
    input  logic [SIMON_WORD_W-1:0] w3,
    input  logic                    z_bit,
    output logic [SIMON_WORD_W-1:0] k_new
);

    logic [SIMON_WORD_W-1:0] w_t0;
    logic [SIMON_WORD_W-1:0] w_t1;

    assign w_t0  = {w3[2:0], w3[SIMON_WORD_W-1:3]} ^ w1;
    assign w_t1  = w_t0 ^ {w_t0[0], w_t0[SIMON_WORD_W-1:1]};
    assign k_new = SIMON_C ^ {{(SIMON_WORD_W-1){1'b0}}, z_bit} ^ w0 ^ w_t1;

endmodule

// File: rtl/simon_key_schedule.sv
// Simon 32/64 key schedule: takes one 64-bit master key, streams round keys k0..k(ROUNDS-1).
// A 4-word sliding window holds k(i)..k(i+3); w[0] is the key currently presented.
module simon_key_schedule
    import simon_pkg::*;
#(
    parameter int WORD_W = SIMON_WORD_W,
    parameter int ROUNDS = SIMON_ROUNDS
) (
    input  logic                 clk,
    input  logic                 rstn,
    simon_key_schedule_if.slave  bus,
    output state_e               o_dbg_state
);

    state_e              r_state;
    state_e              w_next_state;
    logic [WORD_W-1:0]   r_w [4];
    logic [4:0]          r_idx;
    logic [WORD_W-1:0]   w_k_new;
    logic [5:0]          w_z_idx;
    logic                w_key_ready;
    logic                w_rk_valid;
    logic                w_last;
    logic                w_load;
    logic                w_hs;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.key_valid) w_next_state = RUN;
            RUN:     if (bus.rk_ready && w_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_key_ready = 1'b0;
        w_rk_valid  = 1'b0;
        case (r_state)
            IDLE:    w_key_ready = 1'b1;
            RUN:     w_rk_valid  = 1'b1;
            default: w_key_ready = 1'b0;
        endcase
    end

    assign w_last  = (r_idx == 5'(ROUNDS - 1));
    assign w_load  = w_key_ready & bus.key_valid;
    assign w_hs    = w_rk_valid & bus.rk_ready;
    assign w_z_idx = {1'b0, r_idx};

    simon_key_expand u_expand (
        .w0    (r_w[0]),
        .w1    (r_w[1]),
        .w3    (r_w[3]),
        .z_bit (SIMON_Z0[w_z_idx]),
        .k_new (w_k_new)
    );

    // The final accepted key leaves the window untouched; no expansion is needed past it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_w[0] <= '0;
            r_w[1] <= '0;
            r_w[2] <= '0;
            r_w[3] <= '0;
            r_idx  <= '0;
        end else if (w_load) begin
            r_w[0] <= bus.key_in[0*WORD_W +: WORD_W];
            r_w[1] <= bus.key_in[1*WORD_W +: WORD_W];
            r_w[2] <= bus.key_in[2*WORD_W +: WORD_W];
            r_w[3] <= bus.key_in[3*WORD_W +: WORD_W];
            r_idx  <= '0;
        end else if (w_hs && !w_last) begin
            r_w[0] <= r_w[1];
            r_w[1] <= r_w[2];
            r_w[2] <= r_w[3];
            r_w[3] <= w_k_new;
            r_idx  <= r_idx + 5'd1;
        end
    end

    assign bus.key_ready = w_key_ready;
    assign bus.rk_valid  = w_rk_valid;
    assign bus.rk        = r_w[0];
    assign bus.rk_idx    = r_idx;
    assign bus.rk_last   = w_rk_valid & w_last;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_simon_key_schedule.sv
// Directed bench for simon_key_schedule: reference key-schedule model, Simon round model,
// stall/abort/back-to-back sequences and a small table of hand-computed round keys.
module tb_simon_key_schedule;
    import simon_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    simon_key_schedule_if bus ();
    state_e dbg_state;

    simon_key_schedule dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    typedef struct {
        int          idx;
        logic [15:0] rk;
    } vec_t;

    localparam logic [63:0] KEY_A = 64'h1918_1110_0908_0100;
    localparam logic [63:0] KEY_F = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] KEY_B = 64'hDEAD_BEEF_CAFE_F00D;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] cap_rk [32];
    logic        cap_last [32];
    int          next_idx;
    vec_t        vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference key schedule written in the textbook form (~k ^ 3).
    task automatic model_push(input logic [63:0] key);
        logic [15:0] k [32];
        logic [61:0] z;
        logic [15:0] tmp;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            tmp  = {k[i-1][2:0], k[i-1][15:3]};
            tmp  = tmp ^ k[i-3];
            tmp  = tmp ^ {tmp[0], tmp[15:1]};
            k[i] = ~k[i-4] ^ tmp ^ {15'b0, z[61-(i-4)]} ^ 16'd3;
        end
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(k[i]);
        next_idx = 0;
    endtask

    function automatic logic [31:0] encrypt(input logic [31:0] pt);
        logic [15:0] x, y, t, f;
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            f = ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]};
            t = x;
            x = y ^ f ^ cap_rk[i];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic load_key(input logic [63:0] key);
        int n;
        n = 0;
        bus.key_in    = key;
        bus.key_valid = 1'b1;
        while (!bus.key_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("load_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic run_seq(input int stall_pct, input int n_hs);
        int          hs, cyc;
        logic        prev_stall;
        logic [15:0] prev_rk;
        logic [4:0]  prev_idx;
        logic [15:0] exp;
        hs = 0; cyc = 0; prev_stall = 1'b0; prev_rk = '0; prev_idx = '0;
        while (hs < n_hs && cyc < 2000) begin
            if (bus.rk_valid) begin
                if (prev_stall) begin
                    check("rk_stable", bus.rk, prev_rk);
                    check("idx_stable", bus.rk_idx, prev_idx);
                end
                bus.rk_ready = ($urandom_range(99) >= stall_pct);
                if (bus.rk_ready) begin
                    if (exp_q.size() == 0) begin
                        check("exp_q_underflow", 64'd1, 64'd0);
                        exp = '0;
                    end else begin
                        exp = exp_q.pop_front();
                    end
                    check("rk", bus.rk, exp);
                    check("rk_idx", bus.rk_idx, next_idx[4:0]);
                    check("rk_last", bus.rk_last, next_idx == 31);
                    cap_rk[next_idx]   = bus.rk;
                    cap_last[next_idx] = bus.rk_last;
                    next_idx++;
                    hs++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_rk    = bus.rk;
                    prev_idx   = bus.rk_idx;
                end
            end else begin
                check("rk_valid_in_seq", bus.rk_valid, 1'b1);
                bus.rk_ready = 1'($urandom_range(1));
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.rk_ready = 1'b0;
        if (hs < n_hs) check("run_seq_timeout", hs, n_hs);
    endtask

    initial begin
        int          extra, cyc, gap;
        logic        seen_last, done;
        logic [63:0] kb;

        bus.key_in    = '0;
        bus.key_valid = 1'b0;
        bus.rk_ready  = 1'b0;
        rstn          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_key_ready", bus.key_ready, 1'b1);
        check("rst_rk_valid", bus.rk_valid, 1'b0);
        check("rst_rk", bus.rk, 16'h0000);
        check("rst_rk_idx", bus.rk_idx, 5'd0);
        check("rst_rk_last", bus.rk_last, 1'b0);
        check("rst_state", dbg_state, IDLE);
        #3 rstn = 1'b1;
        @(posedge clk); #1;

        // rk_ready while idle must not start anything
        bus.rk_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_rk_ready_valid", bus.rk_valid, 1'b0);
        check("idle_rk_ready_state", dbg_state, IDLE);
        bus.rk_ready = 1'b0;

        // Scenario 1: known vector, rk_ready held high
        vecs[0] = '{0, 16'h0100}; vecs[1] = '{1, 16'h0908};
        vecs[2] = '{2, 16'h1110}; vecs[3] = '{3, 16'h1918};
        vecs[4] = '{4, 16'h71C3}; vecs[5] = '{5, 16'hB649};
        vecs[6] = '{6, 16'h56D4}; vecs[7] = '{7, 16'hE070};
        model_push(KEY_A);
        load_key(KEY_A);
        check("s1_first_valid", bus.rk_valid, 1'b1);
        check("s1_key_ready_run", bus.key_ready, 1'b0);
        run_seq(0, 32);
        check("s1_key_ready_back", bus.key_ready, 1'b1);
        check("s1_rk_valid_off", bus.rk_valid, 1'b0);
        for (int i = 0; i < 8; i++) check("s1_table_rk", cap_rk[vecs[i].idx], vecs[i].rk);
        for (int i = 0; i < 32; i++) check("s1_last_flag", cap_last[i], i == 31);
        check("s1_exp_q_empty", exp_q.size(), 0);

        // Scenario 2: captured round keys drive the Simon round model
        check("s2_ciphertext", encrypt(32'h6565_6877), 32'hC69B_E9BB);

        // Scenario 3: random stalls
        model_push(KEY_A);
        load_key(KEY_A);
        run_seq(50, 32);
        extra = 0;
        bus.rk_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (bus.rk_valid) extra++;
            @(posedge clk); #1;
        end
        bus.rk_ready = 1'b0;
        check("s3_extra_handshakes", extra, 0);

        // Scenario 4: key_valid pulse in RUN at idx 10 is ignored
        model_push(KEY_A);
        load_key(KEY_A);
        run_seq(0, 10);
        check("s4_idx_before", bus.rk_idx, 5'd10);
        bus.key_in    = KEY_F;
        bus.key_valid = 1'b1;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        check("s4_idx_after", bus.rk_idx, 5'd10);
        check("s4_state_run", dbg_state, RUN);
        run_seq(0, 22);
        check("s4_key_ready_back", bus.key_ready, 1'b1);
        model_push(KEY_F);
        load_key(KEY_F);
        run_seq(0, 32);

        // Scenario 5: asynchronous reset mid-run at idx 17
        model_push(KEY_A);
        load_key(KEY_A);
        run_seq(0, 17);
        check("s5_idx_before", bus.rk_idx, 5'd17);
        #3 rstn = 1'b0;
        #1;
        check("s5_rk_valid", bus.rk_valid, 1'b0);
        check("s5_key_ready", bus.key_ready, 1'b1);
        check("s5_state", dbg_state, IDLE);
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        model_push(KEY_A);
        load_key(KEY_A);
        check("s5_restart_rk0", bus.rk, 16'h0100);
        run_seq(0, 32);

        // Scenario 6: back-to-back keys with key_valid held high
        kb = KEY_B;
        bus.rk_ready  = 1'b1;
        bus.key_in    = KEY_A;
        bus.key_valid = 1'b1;
        @(posedge clk); #1;
        bus.key_in = kb;
        cyc = 0; gap = 0; seen_last = 1'b0; done = 1'b0;
        while (!done && cyc < 200) begin
            if (!seen_last) begin
                if (bus.rk_valid && bus.rk_last) seen_last = 1'b1;
            end else if (!bus.rk_valid) begin
                gap++;
            end else begin
                bus.rk_ready  = 1'b0;
                bus.key_valid = 1'b0;
                check("s6_gap", gap, 1);
                check("s6_b_rk0", bus.rk, kb[15:0]);
                check("s6_b_idx0", bus.rk_idx, 5'd0);
                done = 1'b1;
            end
            if (!done) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!done) check("s6_timeout", 64'd1, 64'd0);
        bus.rk_ready  = 1'b0;
        bus.key_valid = 1'b0;
        model_push(kb);
        run_seq(0, 32);
        check("s6_end_key_ready", bus.key_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
